// File: rtl/rand_arbiter_pkg.sv
// rtl/rand_arbiter_pkg.sv - shared types and default sizes for the rand_arbiter slice
package rand_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 6;
  localparam int RES_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rand_arbiter_if.sv
// rtl/rand_arbiter_if.sv - requester and top_rand signal bundle for rand_arbiter
interface rand_arbiter_if
  import rand_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_seed;
  logic [N_REQ-1:0]        gnt;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic [RES_W-1:0]        rsp_result;
  logic                    rsp_err;
  logic                    rnd_start;
  logic [DATA_W-1:0]       rnd_data_in;
  logic                    rnd_done;
  logic [DATA_W-1:0]       rnd_data_out;
  logic [RES_W-1:0]        rnd_result;

  modport master (
    input  req, req_seed, rnd_done, rnd_data_out, rnd_result,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_result, rsp_err,
           rnd_start, rnd_data_in
  );

  modport slave (
    output req, req_seed, rnd_done, rnd_data_out, rnd_result,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_result, rsp_err,
           rnd_start, rnd_data_in
  );

endinterface

// File: rtl/rand_arbiter_rr_picker.sv
// rtl/rand_arbiter_rr_picker.sv - combinational round-robin select starting at ptr
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] idx
);

  // Scan from farthest to nearest so the nearest set bit at/after ptr wins.
  always_comb begin
    int j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = j[$clog2(N_REQ)-1:0];
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin sequencer sharing one top_rand unit among N_REQ requesters
module rand_arbiter
  import rand_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  rand_arbiter_if.master bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, id_q, pick_idx, ptr_next;
  logic              pick_any;
  logic [DATA_W-1:0] seed_q, data_q, pick_seed;
  logic [RES_W-1:0]  res_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_seed   = bus.req_seed[int'(pick_idx)*DATA_W +: DATA_W];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ptr_next    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (bus.rnd_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done is checked before the timeout so a coincident done still returns data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      id_q   <= '0;
      seed_q <= '0;
      data_q <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            id_q   <= pick_idx;
            seed_q <= pick_seed;
          end
        end
        START: cnt_q <= '0;
        WAIT: begin
          if (!timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
          if (bus.rnd_done) begin
            data_q <= bus.rnd_data_out;
            res_q  <= bus.rnd_result;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            res_q  <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP:    ptr_q <= ptr_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.gnt       = '0;
    bus.rnd_start = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    if (state_q != IDLE) bus.gnt[id_q] = 1'b1;
    if (state_q == START) bus.rnd_start = 1'b1;
    if (state_q == RESP) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = id_q;
    end
  end

  assign bus.rnd_data_in = seed_q;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_err     = err_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - directed scoreboard bench for rand_arbiter
module tb_rand_arbiter;
  import rand_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int RW = 2;
  localparam int TO = 64;

  typedef struct {
    int         id;
    logic [5:0] seed;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rand_arbiter_if #(.N_REQ(N), .DATA_W(DW), .RES_W(RW)) bus ();

  rand_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         n_start = 0;
  int         n_resp = 0;
  int         start_cyc = 0;
  int         resp_cyc = 0;
  int         last_resp_cyc = -100;
  int         done_delay = 1;
  int         base_s, base_r;
  logic       prev_start = 1'b0;
  logic       prev_valid = 1'b0;
  logic       resp_done = 1'b0;
  logic       idle_done = 1'b0;
  logic [5:0] seed_cap;
  logic [5:0] seeds [4];
  exp_t       sb[$];

  assign bus.rnd_done = resp_done | idle_done;

  function automatic logic [5:0] mdl_data(input logic [5:0] s);
    return {s[4:0], s[5]} ^ 6'h2A;
  endfunction

  function automatic logic [1:0] mdl_res(input logic [5:0] s);
    return s[1:0] ^ s[5:4];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input int id, input logic err);
    exp_t e;
    e.id   = id;
    e.seed = seeds[id];
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (n_start < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("start_wait", 32'(n_start >= target), 32'd1);
  endtask

  task automatic wait_resps(input int target, input int budget);
    int k;
    k = 0;
    while (n_resp < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rsp_wait", 32'(n_resp >= target), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stand-in for top_rand: answers done_delay cycles after start with the model value.
  initial begin
    bus.rnd_data_out = 6'h3F;
    bus.rnd_result   = 2'h3;
    forever begin
      @(negedge clk);
      if (rst && bus.rnd_start && done_delay > 0) begin
        seed_cap = bus.rnd_data_in;
        repeat (done_delay) @(posedge clk);
        #1;
        resp_done        = 1'b1;
        bus.rnd_data_out = mdl_data(seed_cap);
        bus.rnd_result   = mdl_res(seed_cap);
        @(posedge clk);
        #1;
        resp_done        = 1'b0;
        bus.rnd_data_out = ~mdl_data(seed_cap);
        bus.rnd_result   = ~mdl_res(seed_cap);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (bus.rnd_start) begin
        n_start++;
        start_cyc = cyc;
        check("start_pulse", 32'(prev_start), 32'd0);
        check("idle_gap", 32'(cyc - last_resp_cyc >= 2), 32'd1);
        if (sb.size() == 0) check("start_unexpected", 32'(sb.size()), 32'd1);
        else begin
          check("start_gnt", 32'(bus.gnt), 32'(1 << sb[0].id));
          check("start_seed", 32'(bus.rnd_data_in), 32'(sb[0].seed));
        end
      end
      if (bus.rsp_valid) begin
        n_resp++;
        resp_cyc = cyc;
        last_resp_cyc = cyc;
        check("rsp_pulse", 32'(prev_valid), 32'd0);
        if (sb.size() == 0) check("rsp_unexpected", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_gnt", 32'(bus.gnt), 32'(1 << e.id));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_data", 32'(bus.rsp_data), e.err ? 32'd0 : 32'(mdl_data(e.seed)));
          check("rsp_result", 32'(bus.rsp_result), e.err ? 32'd0 : 32'(mdl_res(e.seed)));
        end
      end
    end
    prev_start = bus.rnd_start;
    prev_valid = bus.rsp_valid;
  end

  initial begin
    seeds = '{6'h3A, 6'h07, 6'h2D, 6'h11};
    bus.req      = '0;
    bus.req_seed = {seeds[3], seeds[2], seeds[1], seeds[0]};
    repeat (2) tick();
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rnd_start", 32'(bus.rnd_start), 32'd0);
    check("rst_rnd_data_in", 32'(bus.rnd_data_in), 32'd0);
    #1 rst = 1'b1;

    // Round-robin with every request held
    done_delay = 1;
    for (int i = 0; i < 5; i++) expect_txn(i % N, 1'b0);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b1111;
    wait_starts(base_s + 5, 200);
    bus.req = 4'b0000;
    wait_resps(base_r + 5, 200);

    // Single request, done five cycles after start
    done_delay = 5;
    expect_txn(2, 1'b0);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b0100;
    wait_starts(base_s + 1, 50);
    wait_resps(base_r + 1, 50);
    bus.req = 4'b0000;
    check("single_latency", 32'(resp_cyc - start_cyc), 32'd6);
    @(negedge clk);
    check("rsp_after_valid", 32'(bus.rsp_valid), 32'd0);
    check("rsp_data_hold", 32'(bus.rsp_data), 32'(mdl_data(6'h2D)));

    // Pointer rotation: 1, then requester 1 re-requests behind 0
    done_delay = 2;
    expect_txn(1, 1'b0);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b0010;
    wait_resps(base_r + 1, 50);
    bus.req = 4'b0011;
    expect_txn(0, 1'b0);
    expect_txn(1, 1'b0);
    wait_starts(base_s + 3, 50);
    bus.req = 4'b0000;
    wait_resps(base_r + 3, 50);

    // Timeout with no done, then a stray done in IDLE
    done_delay = -1;
    expect_txn(3, 1'b1);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b1000;
    wait_starts(base_s + 1, 20);
    wait_resps(base_r + 1, 120);
    bus.req = 4'b0000;
    check("timeout_latency", 32'(resp_cyc - start_cyc), 32'd65);
    idle_done = 1'b1;
    tick();
    idle_done = 1'b0;
    repeat (10) tick();
    check("stray_done_rsp", 32'(n_resp), 32'(base_r + 1));
    check("stray_done_start", 32'(n_start), 32'(base_s + 1));

    // Done arriving in the last timeout cycle
    done_delay = TO;
    expect_txn(0, 1'b0);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b0001;
    wait_starts(base_s + 1, 20);
    wait_resps(base_r + 1, 120);
    bus.req = 4'b0000;
    check("coincide_latency", 32'(resp_cyc - start_cyc), 32'd65);

    // Reset while in WAIT
    done_delay = -1;
    expect_txn(1, 1'b0);
    sb.delete();
    expect_txn(2, 1'b0);
    base_s = n_start;
    base_r = n_resp;
    bus.req = 4'b0100;
    wait_starts(base_s + 1, 20);
    repeat (3) tick();
    rst = 1'b0;
    sb.delete();
    done_delay = 2;
    expect_txn(1, 1'b0);
    bus.req = 4'b1010;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("wait_rst_gnt", 32'(bus.gnt), 32'd0);
    check("wait_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("wait_rst_start", 32'(bus.rnd_start), 32'd0);
    check("wait_rst_seed", 32'(bus.rnd_data_in), 32'd0);
    check("wait_rst_no_rsp", 32'(n_resp), 32'(base_r));
    wait_starts(base_s + 2, 20);
    bus.req = 4'b0000;
    wait_resps(base_r + 1, 50);

    repeat (5) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one top_rand unit (6-bit seed in, 6-bit value plus 2-bit result out) among N_REQ requesters.
- Selects a requester, latches its seed, and pulses the unit's start.
- Waits for the unit's done, then returns data_out and result to the winning requester with a one-cycle response strobe.
- Guards against a hung unit with a timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 6, seed/data width; must match the top_rand data width.
- RES_W, 2, result width; must match the top_rand result width.
- TIMEOUT, 64, maximum WAIT cycles before an error response (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low: state is cleared on a rising clk edge while rst=0.
- req  in  N_REQ  per-requester request level; held high until that requester's response.
- req_seed  in  N_REQ*DATA_W  packed seeds; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot grant, asserted from START through RESP.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_id  out  $clog2(N_REQ)  index of the responding requester.
- rsp_data  out  DATA_W  captured rnd_data_out.
- rsp_result  out  RES_W  captured rnd_result.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- rnd_start  out  1  start pulse to top_rand.
- rnd_data_in  out  DATA_W  seed to top_rand; stable from START until the return to IDLE.
- rnd_done  in  1  done from top_rand.
- rnd_data_out  in  DATA_W  top_rand data_out.
- rnd_result  in  RES_W  top_rand result.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, priority pointer=0, timeout counter=0.
  - All outputs 0: gnt, rsp_*, rnd_start, rnd_data_in.
  - Reset mid-transaction abandons the transaction with no response.
  - top_rand shares clk/rst, so it resets in the same cycle.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit at or after ptr, wrapping N_REQ-1 -> 0.
  - Latch the winner's id and seed, then go to START.
  - If req == 0, stay in IDLE.
- START (exactly 1 cycle):
  - rnd_start=1, rnd_data_in=latched seed, gnt[id]=1, counter cleared.
  - Go to WAIT.
- WAIT:
  - rnd_start=0; counter increments each cycle.
  - rnd_done=1: capture rnd_data_out and rnd_result, rsp_err=0, go to RESP.
  - Otherwise, when counter == TIMEOUT-1: rsp_data=0, rsp_result=0, rsp_err=1, go to RESP.
  - If rnd_done=1 and the timeout occur in the same cycle, done wins (no error).
- RESP (exactly 1 cycle):
  - rsp_valid=1, rsp_id=id, gnt[id]=1.
  - ptr <= (id+1) mod N_REQ; go to IDLE.
  - rsp_data, rsp_result and rsp_err hold their values until the next RESP; they are valid only with rsp_valid.
- Latency:
  - req sampled in IDLE at cycle t: rnd_start at t+1.
  - Done seen at cycle d: rsp_valid at d+1.
  - Minimum request-to-response is 4 cycles when done arrives in the first WAIT cycle.
  - At least one IDLE cycle separates transactions.
- Requester behaviour:
  - req dropping after selection does not abort the transaction; the response is still issued.
  - A requester re-requesting in the IDLE cycle after its RESP has lowest priority.
- rnd_done outside WAIT is ignored.
- Fairness: with all requests continuously asserted, the grant order is 0,1,...,N_REQ-1,0,...
- Counter width is $clog2(TIMEOUT) and it never wraps within WAIT.

Decomposition:
- Package rand_arb_pkg holds:
  - the state enum (IDLE/START/WAIT/RESP);
  - default constants N_REQ_DEF=4, DATA_W_DEF=6, RES_W_DEF=2, TIMEOUT_DEF=64.
- Sub-module rr_picker: combinational round-robin select.
  - Inputs: req, ptr. Outputs: any, idx.
  - Instantiated once; the FSM, seed latch, capture registers and counter stay in rand_arbiter.

Test Plan:
- Single request: req=4'b0100, seed[2]=6'h2D, done 5 cycles after start.
  - Required: rnd_start one cycle with rnd_data_in=6'h2D, gnt=4'b0100.
  - Required: rsp_valid one cycle, rsp_id=2, rsp_data and rsp_result equal the model values, rsp_err=0.
- Round-robin order: req=4'b1111 held throughout.
  - Required: response ids 0,1,2,3,0 in order.
  - Required: an IDLE cycle between consecutive RESP and START.
- Priority rotation: after id 1 completes, assert req=4'b0011.
  - Required: next grant=0? No: the pointer is 2, so the next grant goes to requester 0 only after checking 2 and 3 (both low), giving id 0; then req=4'b0011 again gives id 1.
- Timeout: rnd_done held 0, TIMEOUT=64.
  - Required: rsp_valid at START+65 with rsp_err=1, rsp_data=0, rsp_result=0.
  - Required: rnd_done pulsed in IDLE is ignored (no extra response).
- Reset in WAIT: rst=0 for one edge.
  - Required: state IDLE, gnt=0, no rsp_valid.
  - Required: with req=4'b1010 held, the next grant is 1 (ptr reset to 0).
- Done and timeout coincide: rnd_done=1 in the cycle counter == TIMEOUT-1.
  - Required: rsp_err=0 and captured data returned.
